// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer capture path: writer FSM states and
// capture-mode encodings.
package la_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_BURST,
        S_DRAIN,
        S_DONE
    } cap_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CIRC    = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is visible on dout whenever the
// FIFO is non-empty. Full and empty reflect the count before this cycle's push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/capture_sdram_writer.sv
// Capture-to-DDR writer: buffers one sample word per cycle and writes them to
// the f2h_sdram0 Avalon-MM port as fixed-length bursts, one-shot or circular.
module capture_sdram_writer
    import la_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 27,
    parameter int BURST      = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode_circ,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     region_len,
    input  logic [ADDR_W-1:0]     post_len,
    input  logic                  trigger,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [7:0]            avm_burstcount,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_W-1:0]     wr_ptr,
    output logic [ADDR_W-1:0]     trig_addr
);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   BURST_CNT = CW'(BURST);
    localparam logic [7:0]      BURST_BC  = 8'(BURST);

    cap_state_t state, state_nx;

    logic              mode_r, accepting, triggered;
    logic [ADDR_W-1:0] base_r, len_r, post_r, end_r;
    logic [ADDR_W-1:0] acc_cnt, in_ptr, post_rem, post_left;
    logic [7:0]        bc, bc_nx, beat_cnt;
    logic [CW-1:0]     count;
    logic              full, empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              arm, beat, last_beat;
    logic              trig_fire, post_active, halt_post, accept_now, push;

    // Advance an address, wrapping to the region base in circular mode.
    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] ptr,
                                                  input logic [ADDR_W-1:0] step);
        logic [ADDR_W-1:0] nxt;
        nxt = ptr + step;
        return (mode_r == MODE_CIRC && nxt == end_r) ? base_r : nxt;
    endfunction

    assign arm         = start & (state == S_IDLE || state == S_DONE);
    assign beat        = (state == S_BURST) & ~avm_waitrequest;
    assign last_beat   = beat & (beat_cnt == bc - 8'd1);
    assign trig_fire   = (mode_r == MODE_CIRC) & accepting & trigger & ~triggered;
    assign post_active = triggered | trig_fire;
    assign post_left   = trig_fire ? post_r : post_rem;
    assign halt_post   = post_active & (post_left == '0);
    // A word arriving with the trigger is post-trigger, so post_len=0 refuses it.
    assign accept_now  = accepting & ~abort & ~halt_post;
    assign push        = in_valid & accept_now & ~full;

    assign avm_write      = (state == S_BURST);
    assign avm_address    = wr_ptr;
    assign avm_burstcount = bc;
    assign avm_writedata  = avm_write ? fifo_dout : '0;
    assign avm_byteenable = '1;
    assign busy           = (state != S_IDLE) && (state != S_DONE);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .reset (reset_reset),
        .clear (arm),
        .push  (push),
        .din   (in_data),
        .pop   (beat),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        bc_nx    = BURST_BC;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_CAPTURE;
            S_CAPTURE: begin
                if (count >= BURST_CNT) state_nx = S_BURST;
                else if (!accepting)    state_nx = S_DRAIN;
            end
            S_BURST:   if (last_beat) state_nx = accepting ? S_CAPTURE : S_DRAIN;
            S_DRAIN: begin
                if (empty) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_BURST;
                    if (count < BURST_CNT) bc_nx = 8'(count);
                end
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= S_IDLE;
            mode_r    <= MODE_ONESHOT;
            accepting <= 1'b0;
            triggered <= 1'b0;
            base_r    <= '0;
            len_r     <= '0;
            post_r    <= '0;
            end_r     <= '0;
            acc_cnt   <= '0;
            in_ptr    <= '0;
            post_rem  <= '0;
            bc        <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            trig_addr <= '0;
        end else begin
            state <= state_nx;
            if (arm) begin
                mode_r    <= mode_circ;
                base_r    <= base_addr;
                len_r     <= region_len;
                post_r    <= post_len;
                end_r     <= base_addr + region_len;
                wr_ptr    <= base_addr;
                in_ptr    <= base_addr;
                acc_cnt   <= '0;
                post_rem  <= '0;
                accepting <= 1'b1;
                triggered <= 1'b0;
                done      <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (trig_fire) begin
                    triggered <= 1'b1;
                    trig_addr <= in_ptr;
                    post_rem  <= post_r;
                end
                if (push) begin
                    in_ptr  <= advance(in_ptr, ADDR_W'(1));
                    acc_cnt <= acc_cnt + ADDR_W'(1);
                    if (post_active) post_rem <= post_left - ADDR_W'(1);
                end
                if (in_valid && accept_now && full) overflow <= 1'b1;
                if (abort || halt_post) accepting <= 1'b0;
                if (push && mode_r == MODE_ONESHOT && acc_cnt + ADDR_W'(1) == len_r)
                    accepting <= 1'b0;
                if (push && post_active && post_left == ADDR_W'(1))
                    accepting <= 1'b0;
                if (last_beat) wr_ptr <= advance(wr_ptr, ADDR_W'(bc));
                if (state == S_DRAIN && empty) done <= 1'b1;
            end
            if (state_nx == S_BURST && state != S_BURST) begin
                bc       <= bc_nx;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_capture_sdram_writer.sv
// Directed bench for capture_sdram_writer: a negedge bus monitor records every
// accepted beat, and each scenario compares it against hand-computed results.
module tb_capture_sdram_writer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 27;

    logic              clk = 1'b0;
    logic              reset_reset, start, abort, mode_circ, trigger, in_valid;
    logic [ADDR_W-1:0] base_addr, region_len, post_len;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] avm_address, wr_ptr, trig_addr;
    logic [7:0]        avm_burstcount;
    logic              avm_write, avm_waitrequest, busy, done, overflow;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  wr_rand  = 1'b0;
    logic wr_force = 1'b0;

    always #5 clk = ~clk;

    capture_sdram_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST(8), .FIFO_DEPTH(64)
    ) dut (
        .clk_clk(clk), .reset_reset(reset_reset), .start(start), .abort(abort),
        .mode_circ(mode_circ), .base_addr(base_addr), .region_len(region_len),
        .post_len(post_len), .trigger(trigger), .in_valid(in_valid), .in_data(in_data),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .overflow(overflow),
        .wr_ptr(wr_ptr), .trig_addr(trig_addr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1 avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : wr_force;
    end

    // Bus monitor: logs accepted beats and checks stalled beats stay frozen.
    logic [63:0] q_baddr[$], q_bbc[$], q_addr[$], q_data[$];
    int          beat_idx = 0;
    bit          stall_prev = 1'b0;
    logic [63:0] p_addr, p_bc, p_data;

    always @(negedge clk) begin
        if (reset_reset) begin
            beat_idx   = 0;
            stall_prev = 1'b0;
        end else if (avm_write) begin
            if (stall_prev) begin
                check("hold_addr", 64'(avm_address), p_addr);
                check("hold_bc", 64'(avm_burstcount), p_bc);
                check("hold_data", 64'(avm_writedata), p_data);
            end
            if (avm_waitrequest) begin
                stall_prev = 1'b1;
                p_addr = 64'(avm_address);
                p_bc   = 64'(avm_burstcount);
                p_data = 64'(avm_writedata);
            end else begin
                stall_prev = 1'b0;
                if (beat_idx == 0) begin
                    q_baddr.push_back(64'(avm_address));
                    q_bbc.push_back(64'(avm_burstcount));
                end
                q_addr.push_back(64'(avm_address) + 64'(beat_idx));
                q_data.push_back(64'(avm_writedata));
                beat_idx = (beat_idx + 1 >= int'(avm_burstcount)) ? 0 : beat_idx + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic m, input logic [ADDR_W-1:0] b, l, p);
        mode_circ = m; base_addr = b; region_len = l; post_len = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic send(input int n, input logic [3:0] tag, input int trig_at);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = {tag, 28'(i)};
            trigger  = (i == trig_at);
            tick();
        end
        in_valid = 1'b0;
        trigger  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        check("done", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic check_burst(input int idx, input logic [63:0] a, input logic [63:0] bcnt);
        if (idx < q_baddr.size()) begin
            check("burst_addr", q_baddr[idx], a);
            check("burst_count", q_bbc[idx], bcnt);
        end else begin
            check("burst_missing", 64'(q_baddr.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_beats(input int d0, input int n, input logic [31:0] dbase,
                               input logic [63:0] abase, input int wrap);
        check("beat_total", 64'(q_data.size() - d0), 64'(n));
        for (int k = 0; k < n && d0 + k < q_data.size(); k++) begin
            check("beat_data", q_data[d0 + k], 64'(dbase + 32'(k)));
            check("beat_addr", q_addr[d0 + k], abase + 64'(k % wrap));
        end
    endtask

    initial begin
        int b0, d0;
        reset_reset = 1'b1; start = 1'b0; abort = 1'b0; mode_circ = 1'b0; trigger = 1'b0;
        in_valid = 1'b0; in_data = '0; base_addr = '0; region_len = '0; post_len = '0;
        repeat (3) tick();
        reset_reset = 1'b0;
        tick();

        // Reset state
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_bc", 64'(avm_burstcount), 64'd0);
        check("rst_wdata", 64'(avm_writedata), 64'd0);
        check("rst_be", 64'(avm_byteenable), 64'hF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_wrptr", 64'(wr_ptr), 64'd0);
        check("rst_trig", 64'(trig_addr), 64'd0);

        // One-shot, 16 words, with first-beat latency check
        b0 = q_baddr.size(); d0 = q_data.size();
        arm(1'b0, 27'h100, 27'd16, 27'd0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = {4'h1, 28'(i)};
            tick();
            if (i == 7) check("lat_pre", 64'(avm_write), 64'd0);
            if (i == 8) check("lat_first_beat", 64'(avm_write), 64'd1);
        end
        in_valid = 1'b0;
        wait_done(200);
        check("t1_bursts", 64'(q_baddr.size() - b0), 64'd2);
        check_burst(b0, 64'h100, 64'd8);
        check_burst(b0 + 1, 64'h108, 64'd8);
        check_beats(d0, 16, 32'h1000_0000, 64'h100, 1 << 20);
        check("t1_wrptr", 64'(wr_ptr), 64'h110);
        check("t1_ovf", 64'(overflow), 64'd0);

        // One-shot with random waitrequest
        b0 = q_baddr.size(); d0 = q_data.size();
        arm(1'b0, 27'h200, 27'd32, 27'd0);
        wr_rand = 1'b1;
        send(32, 4'h2, -1);
        wait_done(500);
        wr_rand = 1'b0;
        check("t2_bursts", 64'(q_baddr.size() - b0), 64'd4);
        for (int k = 0; k < 4; k++) check_burst(b0 + k, 64'h200 + 64'(8 * k), 64'd8);
        check_beats(d0, 32, 32'h2000_0000, 64'h200, 1 << 20);
        check("t2_wrptr", 64'(wr_ptr), 64'h220);
        check("t2_ovf", 64'(overflow), 64'd0);

        // Circular, trigger at sample 40, post_len 12
        b0 = q_baddr.size(); d0 = q_data.size();
        arm(1'b1, 27'h400, 27'd32, 27'd12);
        send(60, 4'h3, 40);
        wait_done(300);
        check("t3_trig_addr", 64'(trig_addr), 64'h408);
        check("t3_bursts", 64'(q_baddr.size() - b0), 64'd7);
        check_burst(b0, 64'h400, 64'd8);
        check_burst(b0 + 6, 64'h410, 64'd4);
        check_beats(d0, 52, 32'h3000_0000, 64'h400, 32);
        check("t3_wrptr", 64'(wr_ptr), 64'h414);
        check("t3_ovf", 64'(overflow), 64'd0);

        // Sustained stall: overflow, then abort and drain exactly one FIFO's worth
        b0 = q_baddr.size(); d0 = q_data.size();
        wr_force = 1'b1;
        arm(1'b1, 27'h800, 27'd64, 27'd0);
        send(200, 4'h4, -1);
        check("t4_ovf", 64'(overflow), 64'd1);
        check("t4_no_beats", 64'(q_data.size() - d0), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wr_force = 1'b0;
        wait_done(300);
        check("t4_bursts", 64'(q_baddr.size() - b0), 64'd8);
        check_burst(b0 + 7, 64'h838, 64'd8);
        check_beats(d0, 64, 32'h4000_0000, 64'h800, 64);
        check("t4_wrptr", 64'(wr_ptr), 64'h800);
        check("t4_ovf_sticky", 64'(overflow), 64'd1);

        // Abort during the third beat of the first burst
        b0 = q_baddr.size(); d0 = q_data.size();
        arm(1'b0, 27'h1000, 27'd64, 27'd0);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = {4'h5, 28'(i)};
            abort    = (i == 11);
            if (i == 11) begin
                check("t5_in_burst", 64'(avm_write), 64'd1);
                check("t5_beats_pre_abort", 64'(q_data.size() - d0), 64'd2);
            end
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        wait_done(200);
        check("t5_bursts", 64'(q_baddr.size() - b0), 64'd2);
        check_burst(b0, 64'h1000, 64'd8);
        check_burst(b0 + 1, 64'h1008, 64'd3);
        check_beats(d0, 11, 32'h5000_0000, 64'h1000, 1 << 20);
        check("t5_wrptr", 64'(wr_ptr), 64'h100B);

        // Reset mid-burst, then a normal capture
        arm(1'b0, 27'h40, 27'd16, 27'd0);
        send(10, 4'h6, -1);
        check("t6_in_burst", 64'(avm_write), 64'd1);
        reset_reset = 1'b1;
        tick();
        check("t6_write", 64'(avm_write), 64'd0);
        check("t6_addr", 64'(avm_address), 64'd0);
        check("t6_bc", 64'(avm_burstcount), 64'd0);
        check("t6_wdata", 64'(avm_writedata), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_ovf", 64'(overflow), 64'd0);
        check("t6_wrptr", 64'(wr_ptr), 64'd0);
        check("t6_trig", 64'(trig_addr), 64'd0);
        reset_reset = 1'b0;
        tick();
        b0 = q_baddr.size(); d0 = q_data.size();
        arm(1'b0, 27'h300, 27'd8, 27'd0);
        send(8, 4'h7, -1);
        wait_done(200);
        check("t6_bursts", 64'(q_baddr.size() - b0), 64'd1);
        check_burst(b0, 64'h300, 64'd8);
        check_beats(d0, 8, 32'h7000_0000, 64'h300, 1 << 20);
        check("t6_wrptr_after", 64'(wr_ptr), 64'h308);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/capture_sdram_writer.md
# capture_sdram_writer

Parametrised capture-to-DDR writer for the logic analyzer. Accepts one wide sample word per cycle from the capture pipeline, buffers it in an internal FIFO, and writes it to HPS SDRAM through the f2h_sdram0 Avalon-MM port as fixed-length bursts. Supports one-shot fill and circular pre/post-trigger capture. Control and status are driven by the h2f_lw CSR decoder.

## Interface
Parameters:
- DATA_W, 256, sample/bus word width (bits); byteenable width is DATA_W/8
- ADDR_W, 27, Avalon word-address width
- BURST, 8, beats per full burst; power of two, 1..128
- FIFO_DEPTH, 64, buffer depth in words; power of two, ≥ 2*BURST

Ports:
- clk_clk  in  1  single clock for all logic
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a capture when idle
- abort  in  1  one-cycle pulse; ends a capture early
- mode_circ  in  1  0 = one-shot, 1 = circular; sampled on start
- base_addr  in  ADDR_W  region start; multiple of BURST; sampled on start
- region_len  in  ADDR_W  region length in words; nonzero multiple of BURST; sampled on start
- post_len  in  ADDR_W  words to capture after trigger; circular mode only
- trigger  in  1  trigger pulse; acted on only in circular mode while capturing
- in_valid  in  1  sample present; never stalled
- in_data  in  DATA_W  sample word
- avm_address  out  ADDR_W  burst start address
- avm_burstcount  out  8  beats in the current burst
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  beat data
- avm_byteenable  out  DATA_W/8  all ones
- avm_waitrequest  in  1  slave stall
- busy  out  1  capture in progress
- done  out  1  sticky; capture complete
- overflow  out  1  sticky; at least one sample dropped
- wr_ptr  out  ADDR_W  address of the next word to be written
- trig_addr  out  ADDR_W  address of the first post-trigger word

## Operation
- States: IDLE, CAPTURE, BURST, DRAIN, DONE.
- IDLE: start latches the configuration, clears done, overflow and the FIFO, sets wr_ptr=base_addr, and enters CAPTURE. start is ignored in all other states.
- CAPTURE: every in_valid pushes into the FIFO. When the FIFO is full, the sample is dropped and overflow is set.
  - When FIFO count ≥ BURST, go to BURST with burstcount=BURST.
- BURST: avm_address=wr_ptr and avm_burstcount are held for the entire burst. A beat completes on each cycle with avm_write=1 and avm_waitrequest=0; the FIFO pops on that cycle.
  - After the last beat: wr_ptr += burstcount. In circular mode it wraps to base_addr at base_addr+region_len.
  - Then return to CAPTURE or DRAIN, whichever is active. Samples keep being accepted during a burst.
- One-shot stop: once region_len words have been accepted, further samples are ignored (this is not counted as overflow). Enter DRAIN.
- Circular trigger: the first trigger latches trig_addr, the address of the next accepted word. After post_len more words have been accepted, stop accepting and enter DRAIN. Later triggers are ignored.
  - post_len=0 stops immediately.
  - trigger and in_valid in the same cycle: that word counts as post-trigger.
- DRAIN: issue bursts of min(BURST, count). A final partial burst is allowed. When the FIFO is empty, go to DONE.
- abort: stop accepting. If a burst is in progress, complete it (the Avalon burst must not be truncated), then enter DRAIN.
- DONE: done=1, busy=0. The next start re-arms the block.
- Address arithmetic is modulo 2^ADDR_W. Bursts never cross the wrap point, guaranteed by the alignment requirements.

## Timing
- Reset values: avm_write=0, avm_address=0, avm_burstcount=0, avm_writedata=0, busy=0, done=0, overflow=0, wr_ptr=0, trig_addr=0. The state machine goes to IDLE and the FIFO is emptied. Reset mid-burst abandons the burst.
- Latency: the sample that brings the count to BURST is written on clock edge N. avm_write rises at edge N+1, so the first beat is offered in cycle N+1.
- The FIFO is show-ahead: avm_writedata is valid in every cycle avm_write=1.
- With avm_waitrequest=0 throughout, a full burst takes exactly BURST cycles. There is one idle cycle between back-to-back bursts.
- busy rises the cycle after start and falls the cycle done rises.
- A sample pushed and a beat popped in the same cycle leave the count unchanged. Full and empty are evaluated before that cycle's push and pop.

## Structure
- Package la_pkg: state enum cap_state_t; mode constants MODE_ONESHOT and MODE_CIRC.
- Sub-module sync_fifo: parametrised show-ahead FIFO (WIDTH, DEPTH) with count, full and empty outputs.

## Test plan
- One-shot, base=0x100, len=16, BURST=8, 16 contiguous samples, no waitrequest: two 8-beat bursts at 0x100 and 0x108, data in order, then done=1, wr_ptr=0x110.
- Random waitrequest, 50% duty: address and burstcount stay stable across stalls, beat data is unchanged until accepted, no loss.
- Circular, len=32, post_len=12, trigger at sample 40: trig_addr=base+8, capture stops after sample 51, the final partial burst has burstcount=4, and wr_ptr wraps correctly.
- Waitrequest held high for 200 cycles with continuous samples, FIFO_DEPTH=64: overflow=1, exactly 64 words are eventually written, capture still completes.
- abort during beat 3 of a burst: all 8 beats complete, remaining FIFO words drain, done=1.
- reset_reset asserted mid-burst: avm_write=0 the next cycle, all outputs return to reset values, and a later start behaves normally.
